attn_value_matmul: RTL and testbench

Third attention pipeline stage, directly downstream of the softmax stage. It consumes the registered score matrix S (TOKEN_NUM×TOKEN_NUM) and the forwarded value matrix V (TOKEN_NUM×TOKEN_DIM), and computes O = S·V. The multiply runs k-serially, one outer product per cycle. A valid/ready handshake on each side replaces the free-running register boundary, so the stage can apply back-pressure.

---
 rtl/attn_value_matmul_if.sv | 28 ++
 rtl/attn_value_matmul.sv | 131 +++++++++++++
 tb/tb_attn_value_matmul.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/attn_value_matmul_if.sv
// Handshake bundle for the attention value-matmul stage.
// The upstream side drives S_in/V_in with in_valid. The downstream side
// consumes O_out under out_valid/out_ready.
interface attn_value_matmul_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
) ();
  logic                                     in_valid;
  logic                                     in_ready;
  logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0] S_in;
  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_in;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] O_out;

  // Producer/consumer environment around the stage
  modport master (
    output in_valid, S_in, V_in, out_ready,
    input  in_ready, out_valid, O_out
  );

  // The matmul stage itself
  modport slave (
    input  in_valid, S_in, V_in, out_ready,
    output in_ready, out_valid, O_out
  );
endinterface

// File: rtl/attn_value_matmul.sv
// Attention stage three: O = S * V, computed k-serially.
// Each BUSY cycle adds one outer product (column k of S times row k of V)
// into a full TOKEN_NUM x TOKEN_DIM accumulator array.
// On the last step the stage floors the sums back to the shared Q format,
// saturates them and holds them until downstream accepts.
module attn_value_matmul #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  attn_value_matmul_if.slave   bus
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(TOKEN_NUM);
  localparam int EXT_W  = ACC_W - PROD_W;
  localparam int K_W    = $clog2(TOKEN_NUM);
  localparam int O_W    = DATA_WIDTH * TOKEN_DIM * TOKEN_NUM;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
  localparam logic [DATA_WIDTH-1:0]   OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]   OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  state_t next_state;

  logic signed [DATA_WIDTH-1:0] s_reg [TOKEN_NUM][TOKEN_NUM];
  logic signed [DATA_WIDTH-1:0] v_reg [TOKEN_NUM][TOKEN_DIM];
  logic signed [ACC_W-1:0]      acc   [TOKEN_NUM][TOKEN_DIM];
  logic signed [ACC_W-1:0]      sum   [TOKEN_NUM][TOKEN_DIM];
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      shifted;
  logic [K_W-1:0]               k;
  logic [O_W-1:0]               o_sat;
  logic [O_W-1:0]               o_reg;
  logic                         out_valid_reg;
  logic                         accept;
  logic                         last_step;
  logic                         transfer;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (state == BUSY) && (k == K_W'(TOKEN_NUM - 1));
  assign transfer  = (state == DONE) && bus.out_ready;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.O_out     = o_reg;

  // State register, forced back to IDLE by reset at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode: accept in IDLE, run TOKEN_NUM steps, wait for consumer
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = BUSY;
      BUSY:    if (last_step) next_state = DONE;
      DONE:    if (transfer)  next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Outer-product step, plus floor/saturate of the running sums for output
  always_comb begin
    prod    = '0;
    shifted = '0;
    o_sat   = '0;
    for (int i = 0; i < TOKEN_NUM; i++) begin
      for (int j = 0; j < TOKEN_DIM; j++) begin
        prod      = s_reg[i][k] * v_reg[k][j];
        sum[i][j] = acc[i][j] + {{EXT_W{prod[PROD_W-1]}}, prod};
        shifted   = sum[i][j] >>> FRAC_BITS;
        if (shifted > SAT_MAX)
          o_sat[(i*TOKEN_DIM+j)*DATA_WIDTH +: DATA_WIDTH] = OUT_MAX;
        else if (shifted < SAT_MIN)
          o_sat[(i*TOKEN_DIM+j)*DATA_WIDTH +: DATA_WIDTH] = OUT_MIN;
        else
          o_sat[(i*TOKEN_DIM+j)*DATA_WIDTH +: DATA_WIDTH] = shifted[DATA_WIDTH-1:0];
      end
    end
  end

  // Operand latch, accumulation, result register and out_valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TOKEN_NUM; i++) begin
        for (int c = 0; c < TOKEN_NUM; c++) s_reg[i][c] <= '0;
        for (int j = 0; j < TOKEN_DIM; j++) begin
          v_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
      k             <= '0;
      o_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < TOKEN_NUM; i++) begin
          for (int c = 0; c < TOKEN_NUM; c++)
            s_reg[i][c] <= bus.S_in[(i*TOKEN_NUM+c)*DATA_WIDTH +: DATA_WIDTH];
          for (int j = 0; j < TOKEN_DIM; j++) begin
            v_reg[i][j] <= bus.V_in[(i*TOKEN_DIM+j)*DATA_WIDTH +: DATA_WIDTH];
            acc[i][j]   <= '0;
          end
        end
        k <= '0;
      end else if (state == BUSY) begin
        for (int i = 0; i < TOKEN_NUM; i++)
          for (int j = 0; j < TOKEN_DIM; j++)
            acc[i][j] <= sum[i][j];
        k <= k + K_W'(1);
        if (last_step) begin
          o_reg         <= o_sat;
          out_valid_reg <= 1'b1;
        end
      end else if (transfer) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_attn_value_matmul.sv
// Scoreboard bench for attn_value_matmul: a reference model predicts each
// result at acceptance, and the prediction is popped when the DUT hands it off.
module tb_attn_value_matmul;

  localparam int DW  = 16;
  localparam int FB  = 8;
  localparam int TD  = 4;
  localparam int TN  = 8;
  localparam int S_W = DW * TN * TN;
  localparam int V_W = DW * TD * TN;
  localparam int O_W = DW * TD * TN;

  logic clk;
  logic rst_n;
  int   check_count;
  int   error_count;
  logic [O_W-1:0] expected_q [$];

  attn_value_matmul_if #(.DATA_WIDTH(DW), .TOKEN_DIM(TD), .TOKEN_NUM(TN)) bus ();

  attn_value_matmul #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .TOKEN_DIM(TD), .TOKEN_NUM(TN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [O_W-1:0] actual,
                             input logic [O_W-1:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference model: exact integer sum, floor shift, saturate
  function automatic logic [O_W-1:0] computeExpected(input logic [S_W-1:0] s,
                                                    input logic [V_W-1:0] v);
    logic [O_W-1:0] res;
    logic [DW-1:0]  sv;
    logic [DW-1:0]  vv;
    longint         total;
    longint         q;
    longint         max_v;
    longint         min_v;
    max_v = (longint'(1) <<< (DW - 1)) - 1;
    min_v = -(longint'(1) <<< (DW - 1));
    res = '0;
    for (int r = 0; r < TN; r++) begin
      for (int j = 0; j < TD; j++) begin
        total = 0;
        for (int kk = 0; kk < TN; kk++) begin
          sv = s[(r*TN+kk)*DW +: DW];
          vv = v[(kk*TD+j)*DW +: DW];
          total += longint'($signed(sv)) * longint'($signed(vv));
        end
        q = total >>> FB;
        if (q > max_v) q = max_v;
        if (q < min_v) q = min_v;
        res[(r*TD+j)*DW +: DW] = q[DW-1:0];
      end
    end
    return res;
  endfunction

  // Drive one matrix pair at a negedge and record its prediction when accepted
  task automatic applyStimulus(input logic [S_W-1:0] s, input logic [V_W-1:0] v);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_before_accept", O_W'(bus.in_ready), O_W'(1));
    bus.S_in     = s;
    bus.V_in     = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    expected_q.push_back(computeExpected(s, v));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.S_in     = '0;
    bus.V_in     = '0;
  endtask

  // Count cycles from acceptance until out_valid appears
  task automatic waitResult();
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("latency", O_W'(lat), O_W'(TN));
  endtask

  // Hold off the consumer for 'hold' cycles while poking in_valid, then take the result
  task automatic collectResult(input int hold);
    logic [O_W-1:0] snap;
    logic [O_W-1:0] exp_o;
    snap = bus.O_out;
    bus.out_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      bus.in_valid = c[0] ? 1'b0 : 1'b1;
      bus.S_in     = {S_W/32{$urandom()}};
      bus.V_in     = {V_W/32{$urandom()}};
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_O_stable", bus.O_out, snap);
      checkOutput("hold_in_ready", O_W'(bus.in_ready), O_W'(0));
      checkOutput("hold_out_valid", O_W'(bus.out_valid), O_W'(1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (expected_q.size() == 0) begin
      checkOutput("scoreboard_empty", O_W'(1), O_W'(0));
      exp_o = '0;
    end else begin
      exp_o = expected_q.pop_front();
    end
    checkOutput("O_out", bus.O_out, exp_o);
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("post_xfer_out_valid", O_W'(bus.out_valid), O_W'(0));
    checkOutput("post_xfer_in_ready", O_W'(bus.in_ready), O_W'(1));
    checkOutput("post_xfer_O_kept", bus.O_out, exp_o);
  endtask

  function automatic logic [S_W-1:0] identityS();
    logic [S_W-1:0] s;
    s = '0;
    for (int r = 0; r < TN; r++) s[(r*TN+r)*DW +: DW] = 16'h0100;
    return s;
  endfunction

  function automatic logic [V_W-1:0] randomV();
    logic [V_W-1:0] v;
    for (int e = 0; e < TN*TD; e++) v[e*DW +: DW] = DW'($urandom());
    return v;
  endfunction

  function automatic logic [S_W-1:0] fillS(input logic [DW-1:0] val);
    logic [S_W-1:0] s;
    for (int e = 0; e < TN*TN; e++) s[e*DW +: DW] = val;
    return s;
  endfunction

  function automatic logic [V_W-1:0] fillV(input logic [DW-1:0] val);
    logic [V_W-1:0] v;
    for (int e = 0; e < TN*TD; e++) v[e*DW +: DW] = val;
    return v;
  endfunction

  initial begin
    logic [S_W-1:0] s;
    logic [V_W-1:0] v;
    logic [O_W-1:0] hand;
    logic           seen_valid;

    check_count   = 0;
    error_count   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.S_in      = '0;
    bus.V_in      = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", O_W'(bus.in_ready), O_W'(1));
    checkOutput("reset_out_valid", O_W'(bus.out_valid), O_W'(0));
    checkOutput("reset_O_out", bus.O_out, '0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] identity");
    v = randomV();
    applyStimulus(identityS(), v);
    waitResult();
    checkOutput("identity_equals_V", bus.O_out, v);
    collectResult(0);

    $display("[TB] averaging");
    for (int kk = 0; kk < TN; kk++)
      for (int j = 0; j < TD; j++)
        v[(kk*TD+j)*DW +: DW] = DW'(16'h0100 * (j + 1));
    applyStimulus(fillS(16'h0020), v);
    waitResult();
    hand = '0;
    for (int r = 0; r < TN; r++)
      for (int j = 0; j < TD; j++)
        hand[(r*TD+j)*DW +: DW] = DW'(16'h0100 * (j + 1));
    checkOutput("averaging_rows", bus.O_out, hand);
    collectResult(0);

    $display("[TB] saturation");
    applyStimulus(fillS(16'h0100), fillV(16'h7FFF));
    waitResult();
    checkOutput("sat_pos", bus.O_out, {TN*TD{16'h7FFF}});
    collectResult(0);
    applyStimulus(fillS(16'h0100), fillV(16'h8000));
    waitResult();
    checkOutput("sat_neg", bus.O_out, {TN*TD{16'h8000}});
    collectResult(0);

    $display("[TB] floor rounding");
    s = '0;
    v = '0;
    s[DW-1:0] = 16'h0080;
    v[DW-1:0] = 16'hFFFF;
    applyStimulus(s, v);
    waitResult();
    hand = '0;
    hand[DW-1:0] = 16'hFFFF;
    checkOutput("floor_result", bus.O_out, hand);
    collectResult(0);

    $display("[TB] back-pressure");
    s = '0;
    for (int e = 0; e < TN*TN; e++) s[e*DW +: DW] = DW'($urandom_range(0, 16'h00FF));
    applyStimulus(s, randomV());
    waitResult();
    collectResult(5);
    applyStimulus(identityS(), randomV());
    waitResult();
    collectResult(0);

    $display("[TB] reset during BUSY");
    applyStimulus(fillS(16'h0100), fillV(16'h0123));
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    void'(expected_q.pop_back());
    #1;
    checkOutput("midreset_out_valid", O_W'(bus.out_valid), O_W'(0));
    checkOutput("midreset_O_out", bus.O_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_in_ready", O_W'(bus.in_ready), O_W'(1));
    seen_valid = 1'b0;
    repeat (TN + 4) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    checkOutput("aborted_never_emitted", O_W'(seen_valid), O_W'(0));
    v = randomV();
    applyStimulus(identityS(), v);
    waitResult();
    checkOutput("identity_after_reset", bus.O_out, v);
    collectResult(0);

    checkOutput("scoreboard_drained", O_W'(expected_q.size()), O_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
